// File: rtl/vi_pkg.sv
// Shared encodings and defaults for the register-file hazard scoreboard.
package vi_pkg;
  localparam int REG_ADDR_W  = 5;
  localparam int CNT_W       = 3;
  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_LD_LAT  = 2;
  localparam int DEF_ALU_LAT = 1;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_RSV  = 2'd3
  } cls_e;

  // Reserved class behaves as ALU.
  function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] cls, input int alu_lat,
                                              input int ld_lat, input int mul_lat);
    case (cls)
      CLS_LOAD: lat_of = CNT_W'(ld_lat);
      CLS_MUL:  lat_of = CNT_W'(mul_lat);
      default:  lat_of = CNT_W'(alu_lat);
    endcase
  endfunction
endpackage

// File: rtl/sb_entry.sv
// One tracked register: pending flag, forwarding countdown and latency class.
module sb_entry
  import vi_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_all_i,
  input  logic             arm_i,
  input  logic [CNT_W-1:0] arm_cnt_i,
  input  logic [1:0]       arm_cls_i,
  input  logic             wb_clr_i,
  input  logic             hold_i,
  output logic             pend_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cls_q, cls_d;

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    cls_d  = cls_q;
    // A load on a cache miss parks at 1 so it never looks forwardable early.
    if (pend_q && cnt_q != '0 &&
        !(cls_q == CLS_LOAD && cnt_q == CNT_W'(1) && hold_i))
      cnt_d = cnt_q - CNT_W'(1);
    if (wb_clr_i) begin
      pend_d = 1'b0;
      cnt_d  = '0;
    end
    if (arm_i) begin
      pend_d = 1'b1;
      cnt_d  = arm_cnt_i;
      cls_d  = arm_cls_i;
    end
    if (clr_all_i) begin
      pend_d = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
      cls_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      cls_q  <= cls_d;
    end
  end

  assign pend_o = pend_q;
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/wb_scoreboard.sv
// Decode-side hazard tracker: per-register pending state, read/WAW stall and forward flags.
module wb_scoreboard
  import vi_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int LD_LAT  = DEF_LD_LAT,
  parameter int ALU_LAT = DEF_ALU_LAT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  iss_valid_i,
  input  logic                  iss_wr_en_i,
  input  logic [REG_ADDR_W-1:0] iss_rd_i,
  input  logic [1:0]            iss_class_i,
  input  logic [REG_ADDR_W-1:0] iss_rs_a_i,
  input  logic [REG_ADDR_W-1:0] iss_rs_b_i,
  input  logic                  mem_stall_i,
  input  logic                  wb_en_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic                  flush_i,
  output logic                  fwd_a_o,
  output logic                  fwd_b_o,
  output logic                  stall_o,
  output logic                  busy_o
);
  if (MUL_LAT > 7 || LD_LAT > 7 || ALU_LAT > 7) begin : g_lat_chk
    $error("latency does not fit the 3-bit countdown");
  end

  logic [NREG-1:0]            pend_w;
  logic [NREG-1:0][CNT_W-1:0] cnt_w;
  logic [CNT_W-1:0]           lat_w;
  logic                       haz_a, haz_b, waw, accept;

  // x0 is hardwired clear so address 0 never hazards.
  assign pend_w[0] = 1'b0;
  assign cnt_w[0]  = '0;
  assign lat_w     = lat_of(iss_class_i, ALU_LAT, LD_LAT, MUL_LAT);

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    sb_entry u_ent (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_all_i (flush_i),
      .arm_i     (accept && iss_wr_en_i && iss_rd_i == REG_ADDR_W'(r)),
      .arm_cnt_i (lat_w),
      .arm_cls_i (iss_class_i),
      .wb_clr_i  (wb_en_i && wb_addr_i == REG_ADDR_W'(r)),
      .hold_i    (mem_stall_i),
      .pend_o    (pend_w[r]),
      .cnt_o     (cnt_w[r])
    );
  end

  always_comb begin
    haz_a   = pend_w[iss_rs_a_i] && cnt_w[iss_rs_a_i] != '0;
    haz_b   = pend_w[iss_rs_b_i] && cnt_w[iss_rs_b_i] != '0;
    fwd_a_o = pend_w[iss_rs_a_i] && cnt_w[iss_rs_a_i] == '0;
    fwd_b_o = pend_w[iss_rs_b_i] && cnt_w[iss_rs_b_i] == '0;
    waw     = iss_wr_en_i && pend_w[iss_rd_i] && cnt_w[iss_rd_i] > lat_w;
    stall_o = iss_valid_i && (haz_a || haz_b || waw);
    accept  = iss_valid_i && !stall_o && !flush_i;
    busy_o  = |pend_w;
  end

  // Retiring a register whose result is not yet forwardable means a broken pipeline.
  always @(posedge clk_i) begin
    if (!rst_i && !flush_i && wb_en_i)
      assert (cnt_w[wb_addr_i] == '0) else $error("early retire of x%0d", wb_addr_i);
  end
endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed plus randomized bench for wb_scoreboard against an array-based reference model.
module tb_wb_scoreboard;
  logic       clk_i = 1'b0;
  logic       rst_i, iss_valid_i, iss_wr_en_i, mem_stall_i, wb_en_i, flush_i;
  logic [4:0] iss_rd_i, iss_rs_a_i, iss_rs_b_i, wb_addr_i;
  logic [1:0] iss_class_i;
  logic       fwd_a_o, fwd_b_o, stall_o, busy_o;

  int checks = 0;
  int failures = 0;
  int m_pend[32], m_cnt[32], m_cls[32];

  always #5 clk_i = ~clk_i;

  wb_scoreboard dut (
    .clk_i(clk_i), .rst_i(rst_i), .iss_valid_i(iss_valid_i), .iss_wr_en_i(iss_wr_en_i),
    .iss_rd_i(iss_rd_i), .iss_class_i(iss_class_i), .iss_rs_a_i(iss_rs_a_i),
    .iss_rs_b_i(iss_rs_b_i), .mem_stall_i(mem_stall_i), .wb_en_i(wb_en_i),
    .wb_addr_i(wb_addr_i), .flush_i(flush_i), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .stall_o(stall_o), .busy_o(busy_o)
  );

  function automatic int lat(input int c);
    return (c == 2) ? 5 : (c == 1) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic iss(input logic v, input logic we, input int rd, input int c,
                     input int a, input int b);
    iss_valid_i = v; iss_wr_en_i = we; iss_rd_i = 5'(rd);
    iss_class_i = 2'(c); iss_rs_a_i = 5'(a); iss_rs_b_i = 5'(b);
  endtask

  // One clock: compare outputs against the model, then advance the model with the same inputs.
  task automatic cycle(input bit chk);
    bit ha, hb, waw, st, acc, bz, fa, fb;
    int a, b, rd;
    #1;
    a = int'(iss_rs_a_i); b = int'(iss_rs_b_i); rd = int'(iss_rd_i);
    fa  = a != 0 && m_pend[a] != 0 && m_cnt[a] == 0;
    fb  = b != 0 && m_pend[b] != 0 && m_cnt[b] == 0;
    ha  = a != 0 && m_pend[a] != 0 && m_cnt[a] != 0;
    hb  = b != 0 && m_pend[b] != 0 && m_cnt[b] != 0;
    waw = iss_wr_en_i && rd != 0 && m_pend[rd] != 0 && m_cnt[rd] > lat(int'(iss_class_i));
    st  = iss_valid_i && (ha || hb || waw);
    acc = iss_valid_i && !st && !flush_i;
    bz  = 1'b0;
    for (int r = 1; r < 32; r++) if (m_pend[r] != 0) bz = 1'b1;
    if (chk) begin
      check("fwd_a", fwd_a_o, fa);
      check("fwd_b", fwd_b_o, fb);
      check("stall", stall_o, st);
      check("busy", busy_o, bz);
    end
    @(posedge clk_i);
    if (rst_i) begin
      for (int r = 0; r < 32; r++) begin m_pend[r] = 0; m_cnt[r] = 0; m_cls[r] = 0; end
    end else if (flush_i) begin
      for (int r = 0; r < 32; r++) begin m_pend[r] = 0; m_cnt[r] = 0; end
    end else begin
      for (int r = 1; r < 32; r++)
        if (m_pend[r] != 0 && m_cnt[r] > 0 && !(m_cls[r] == 1 && m_cnt[r] == 1 && mem_stall_i))
          m_cnt[r]--;
      if (wb_en_i && wb_addr_i != 0) begin m_pend[wb_addr_i] = 0; m_cnt[wb_addr_i] = 0; end
      if (acc && iss_wr_en_i && rd != 0) begin
        m_pend[rd] = 1; m_cnt[rd] = lat(int'(iss_class_i)); m_cls[rd] = int'(iss_class_i);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic idle();
    iss(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wb(input int addr);
    idle(); wb_en_i = 1'b1; wb_addr_i = 5'(addr); cycle(1); wb_en_i = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin m_pend[r] = 0; m_cnt[r] = 0; m_cls[r] = 0; end
    rst_i = 1'b1; mem_stall_i = 1'b0; wb_en_i = 1'b0; wb_addr_i = '0; flush_i = 1'b0;
    idle();
    @(negedge clk_i);
    cycle(0);
    cycle(1);
    rst_i = 1'b0;
    cycle(1);

    // ALU result: one cycle of countdown, then forwardable
    iss(1, 1, 5, 0, 0, 0); cycle(1);
    iss(1, 0, 0, 0, 5, 0); cycle(1); cycle(1);

    // MUL result observed on operand B until it forwards
    iss(1, 1, 7, 2, 0, 0); cycle(1);
    iss(1, 0, 0, 0, 0, 7); repeat (6) cycle(1);

    // Load parked at 1 by a cache miss
    iss(1, 1, 3, 1, 0, 0); mem_stall_i = 1'b1; cycle(1);
    iss(1, 0, 0, 0, 3, 0); repeat (6) cycle(1);
    mem_stall_i = 1'b0; repeat (2) cycle(1);
    wb(5); wb(7); wb(3);

    // WAW: ALU to rd=9 behind an in-flight MUL
    iss(1, 1, 9, 2, 0, 0); cycle(1);
    idle(); cycle(1);
    iss(1, 1, 9, 0, 0, 0); repeat (3) cycle(1);
    iss(1, 0, 0, 0, 9, 9); repeat (2) cycle(1);
    wb(9);

    // Accept and writeback of the same rd in one cycle re-arms it
    iss(1, 1, 4, 0, 0, 0); wb_en_i = 1'b1; wb_addr_i = 5'd4; cycle(1); wb_en_i = 1'b0;
    iss(1, 0, 0, 0, 4, 0); cycle(1); cycle(1);
    wb(4);

    // Flush, then reset mid-MUL, then rd=0 write
    iss(1, 1, 10, 0, 0, 0); cycle(1);
    iss(1, 1, 11, 2, 0, 0); cycle(1);
    iss(1, 1, 12, 1, 0, 0); cycle(1);
    iss(1, 0, 0, 0, 11, 10); flush_i = 1'b1; cycle(1); flush_i = 1'b0;
    iss(1, 0, 0, 0, 11, 10); cycle(1);
    iss(1, 1, 13, 2, 0, 0); cycle(1);
    idle(); rst_i = 1'b1; cycle(1); rst_i = 1'b0;
    iss(1, 1, 0, 2, 0, 0); cycle(1);
    iss(1, 0, 0, 0, 13, 0); cycle(1); cycle(1);

    // Randomized traffic on a small register window to keep hazards frequent
    for (int i = 0; i < 500; i++) begin
      int wa;
      iss($urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(7), $urandom_range(3),
          $urandom_range(7), $urandom_range(7));
      mem_stall_i = $urandom_range(3) == 0;
      flush_i     = $urandom_range(31) == 0;
      rst_i       = $urandom_range(99) == 0;
      wa = $urandom_range(7);
      wb_addr_i = 5'(wa);
      wb_en_i = $urandom_range(1) == 1 && !(m_pend[wa] != 0 && m_cnt[wa] != 0);
      cycle(1);
    end
    idle(); mem_stall_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0; wb_en_i = 1'b0;
    cycle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
